// File: rtl/matrix_mem_responder.sv
// Matrix memory responder: preloadable word array served over the rreq/rrdy read handshake
// with configurable latency and backpressure. Define MATRIX_MEM_STAT_EN to add request/stall counters.
module matrix_mem_responder #(
    parameter int          DATA_W     = 256,
    parameter int          ADDR_W     = 10,
    parameter int          DEPTH      = 1024,
    parameter int          LATENCY    = 1,
    parameter int          STALL_MODE = 1,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1,
    parameter int          READY_RUN  = 3,
    parameter int          STALL_RUN  = 1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_mem_rreq,
    input  logic [ADDR_W-1:0] i_mem_addr,
    output logic              o_mem_rrdy,
    output logic [DATA_W-1:0] o_mem_dout,
    output logic              o_mem_dout_vld,
    input  logic              i_load_en,
    input  logic [ADDR_W-1:0] i_load_addr,
    input  logic [DATA_W-1:0] i_load_data,
    output logic              o_busy
`ifdef MATRIX_MEM_STAT_EN
    ,
    output logic [31:0]       o_req_cnt,
    output logic [31:0]       o_stall_cnt
`endif
);

    localparam int              IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_C    = (ADDR_W + 1)'(DEPTH);
    localparam logic [15:0]     READY_C    = 16'(READY_RUN);
    localparam logic [15:0]     DUTY_LAST  = 16'(READY_RUN + STALL_RUN - 1);
    // In LFSR mode the ready flop mirrors LFSR bit 0, so its reset value follows the seed.
    localparam logic            RRDY_RST   = (STALL_MODE == 1) ? LFSR_SEED[0] : 1'b1;

    logic [DATA_W-1:0]             mem_q [DEPTH];
    logic [15:0]                   lfsr_q, lfsr_d;
    logic [15:0]                   duty_q, duty_d;
    logic                          rrdy_q, rrdy_d;
    logic [LATENCY-1:0]            vld_q, vld_d;
    logic [LATENCY-1:0][DATA_W-1:0] data_q, data_d;
    logic                          accept_s;
    logic                          rd_in_range_s;
    logic                          ld_in_range_s;
    logic [DATA_W-1:0]             rd_word_s;
`ifdef MATRIX_MEM_STAT_EN
    logic [31:0]                   req_cnt_q, req_cnt_d;
    logic [31:0]                   stall_cnt_q, stall_cnt_d;
`endif

    // Fibonacci LFSR, taps 16,14,13,11, shifting toward bit 0.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    // Acceptance, address decode and array read.
    always_comb begin
        accept_s      = i_mem_rreq & rrdy_q;
        rd_in_range_s = ({1'b0, i_mem_addr} < DEPTH_C);
        ld_in_range_s = ({1'b0, i_load_addr} < DEPTH_C);
        if (rd_in_range_s) begin
            rd_word_s = mem_q[i_mem_addr[IDX_W-1:0]];
        end else begin
            rd_word_s = '0;
        end
    end

    // Latency pipeline; empty stages carry zero data so the output is zero when not valid.
    always_comb begin
        vld_d  = '0;
        data_d = '0;
        vld_d[0] = accept_s;
        if (accept_s) begin
            data_d[0] = rd_word_s;
        end else begin
            data_d[0] = '0;
        end
        for (int i = 1; i < LATENCY; i++) begin
            vld_d[i]  = vld_q[i-1];
            data_d[i] = data_q[i-1];
        end
    end

    // Backpressure generators; ready is computed one cycle ahead and registered.
    always_comb begin
        lfsr_d = lfsr_next(lfsr_q);
        if (duty_q == DUTY_LAST) begin
            duty_d = 16'd0;
        end else begin
            duty_d = duty_q + 16'd1;
        end
        case (STALL_MODE)
            0:       rrdy_d = 1'b1;
            1:       rrdy_d = lfsr_d[0];
            2:       rrdy_d = (duty_d < READY_C);
            default: rrdy_d = 1'b1;
        endcase
    end

`ifdef MATRIX_MEM_STAT_EN
    // Saturating statistics counters.
    always_comb begin
        req_cnt_d   = req_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (accept_s && (req_cnt_q != 32'hFFFF_FFFF)) begin
            req_cnt_d = req_cnt_q + 32'd1;
        end else begin
            req_cnt_d = req_cnt_q;
        end
        if (i_mem_rreq && !rrdy_q && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end
`endif

    // Control and pipeline state with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            lfsr_q      <= LFSR_SEED;
            duty_q      <= 16'd0;
            rrdy_q      <= RRDY_RST;
            vld_q       <= '0;
            data_q      <= '0;
`ifdef MATRIX_MEM_STAT_EN
            req_cnt_q   <= 32'd0;
            stall_cnt_q <= 32'd0;
`endif
        end else begin
            lfsr_q      <= lfsr_d;
            duty_q      <= duty_d;
            rrdy_q      <= rrdy_d;
            vld_q       <= vld_d;
            data_q      <= data_d;
`ifdef MATRIX_MEM_STAT_EN
            req_cnt_q   <= req_cnt_d;
            stall_cnt_q <= stall_cnt_d;
`endif
        end
    end

    // Preload port; not reset, and the read above sees the pre-write word (read-first).
    always_ff @(posedge i_clk) begin
        if (i_load_en && ld_in_range_s) begin
            mem_q[i_load_addr[IDX_W-1:0]] <= i_load_data;
        end
    end

    assign o_mem_rrdy     = rrdy_q;
    assign o_mem_dout     = data_q[LATENCY-1];
    assign o_mem_dout_vld = vld_q[LATENCY-1];
    assign o_busy         = |vld_q;
`ifdef MATRIX_MEM_STAT_EN
    assign o_req_cnt      = req_cnt_q;
    assign o_stall_cnt    = stall_cnt_q;
`endif

endmodule

// File: tb/tb_matrix_mem_responder.sv
// Scoreboard bench for matrix_mem_responder: three instances (always-ready LAT3 DEPTH512,
// duty-cycle LAT1, LFSR LAT2) driven by directed vectors; a negedge monitor pops expectations.
module tb_matrix_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         a_req, a_ld, bc_req, bc_ld;
    logic [9:0]   a_addr, a_ldaddr, bc_addr, bc_ldaddr;
    logic [255:0] a_lddata, bc_lddata;
    logic         a_rdy, a_vld, a_busy, b_rdy, b_vld, b_busy, c_rdy, c_vld, c_busy;
    logic [255:0] a_dout, b_dout, c_dout;
`ifdef MATRIX_MEM_STAT_EN
    logic [31:0]  a_rc, a_sc, b_rc, b_sc, c_rc, c_sc;
`endif

    matrix_mem_responder #(.DATA_W(256), .ADDR_W(10), .DEPTH(512), .LATENCY(3), .STALL_MODE(0)) u_a (
        .i_clk(clk), .i_reset(rst), .i_mem_rreq(a_req), .i_mem_addr(a_addr),
        .o_mem_rrdy(a_rdy), .o_mem_dout(a_dout), .o_mem_dout_vld(a_vld),
        .i_load_en(a_ld), .i_load_addr(a_ldaddr), .i_load_data(a_lddata), .o_busy(a_busy)
`ifdef MATRIX_MEM_STAT_EN
        , .o_req_cnt(a_rc), .o_stall_cnt(a_sc)
`endif
    );

    matrix_mem_responder #(.DATA_W(256), .ADDR_W(10), .DEPTH(1024), .LATENCY(1), .STALL_MODE(2),
                           .READY_RUN(3), .STALL_RUN(1)) u_b (
        .i_clk(clk), .i_reset(rst), .i_mem_rreq(bc_req), .i_mem_addr(bc_addr),
        .o_mem_rrdy(b_rdy), .o_mem_dout(b_dout), .o_mem_dout_vld(b_vld),
        .i_load_en(bc_ld), .i_load_addr(bc_ldaddr), .i_load_data(bc_lddata), .o_busy(b_busy)
`ifdef MATRIX_MEM_STAT_EN
        , .o_req_cnt(b_rc), .o_stall_cnt(b_sc)
`endif
    );

    matrix_mem_responder #(.DATA_W(256), .ADDR_W(10), .DEPTH(1024), .LATENCY(2), .STALL_MODE(1),
                           .LFSR_SEED(16'hACE1)) u_c (
        .i_clk(clk), .i_reset(rst), .i_mem_rreq(bc_req), .i_mem_addr(bc_addr),
        .o_mem_rrdy(c_rdy), .o_mem_dout(c_dout), .o_mem_dout_vld(c_vld),
        .i_load_en(bc_ld), .i_load_addr(bc_ldaddr), .i_load_data(bc_lddata), .o_busy(c_busy)
`ifdef MATRIX_MEM_STAT_EN
        , .o_req_cnt(c_rc), .o_stall_cnt(c_sc)
`endif
    );

    typedef struct {
        logic [255:0] data;
        int           due;
        int           acc;
    } exp_t;

    exp_t        q [3][$];
    int          cyc = 0;
    int          sr = 0;
    logic [15:0] lf = 16'hACE1;
    int          checks = 0;
    int          failures = 0;
    bit          mon_en = 1'b0;

    logic [255:0] w_a5, w_x, w_y, w_z, w_p88, w_j600, w_v9, w_v5;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
        end
    endtask

    task automatic push(input int k, input logic [255:0] d, input int lat);
        exp_t e;
        e.data = d;
        e.due  = cyc + lat;
        e.acc  = cyc + 1;
        q[k].push_back(e);
    endtask

    function automatic logic [255:0] w_idx(input int i);
        logic [31:0] v;
        v = 32'hC0DE_0000 | 32'(i);
        return {8{v}};
    endfunction

    // Reference models of ready patterns; reset discards all outstanding expectations.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            sr <= 0;
            lf <= 16'hACE1;
            for (int k = 0; k < 3; k++) q[k].delete();
        end else begin
            sr <= sr + 1;
            lf <= {lf[0] ^ lf[2] ^ lf[3] ^ lf[5], lf[15:1]};
        end
    end

    task automatic mon(input int k, input string nm, input logic vld, input logic [255:0] dout,
                       input logic busy);
        logic eb;
        eb = 1'b0;
        for (int i = 0; i < q[k].size(); i++) begin
            if (q[k][i].acc <= cyc && cyc <= q[k][i].due) eb = 1'b1;
        end
        chk({nm, "_busy"}, 256'(busy), 256'(eb));
        while (q[k].size() > 0 && q[k][0].due < cyc) begin
            checks++;
            failures++;
            $display("FAIL %s_missing_valid cyc=%0d got=none exp_due=%0d", nm, cyc, q[k][0].due);
            void'(q[k].pop_front());
        end
        if (vld) begin
            if (q[k].size() == 0 || q[k][0].due != cyc) begin
                checks++;
                failures++;
                $display("FAIL %s_unexpected_valid cyc=%0d got=%h exp=no_valid", nm, cyc, dout);
            end else begin
                chk({nm, "_data"}, dout, q[k][0].data);
                void'(q[k].pop_front());
            end
        end else begin
            chk({nm, "_idle_dout"}, dout, 256'd0);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon(0, "a", a_vld, a_dout, a_busy);
            mon(1, "b", b_vld, b_dout, b_busy);
            mon(2, "c", c_vld, c_dout, c_busy);
            chk("a_rrdy", 256'(a_rdy), 256'(1'b1));
            chk("b_rrdy", 256'(b_rdy), 256'((sr % 4) != 3));
            chk("c_rrdy", 256'(c_rdy), 256'(lf[0]));
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic rd_a(input logic [9:0] ad, input logic [255:0] d);
        a_req  = 1'b1;
        a_addr = ad;
        push(0, d, 3);
    endtask

    task automatic rd_bc(input logic [9:0] ad, input logic [255:0] d);
        bc_req  = 1'b1;
        bc_addr = ad;
        if ((sr % 4) != 3) push(1, d, 1);
        if (lf[0]) push(2, d, 2);
    endtask

    task automatic ld_a(input logic [9:0] ad, input logic [255:0] d);
        a_ld     = 1'b1;
        a_ldaddr = ad;
        a_lddata = d;
    endtask

    task automatic idle(input int n);
        a_req  = 1'b0;
        bc_req = 1'b0;
        a_ld   = 1'b0;
        bc_ld  = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        w_a5   = {32{8'hA5}};
        w_x    = {16{16'h1111}};
        w_y    = {16{16'h2222}};
        w_z    = {16{16'h5A5A}};
        w_p88  = {16{16'h0088}};
        w_j600 = {16{16'hDEAD}};
        w_v9   = {16{16'h0909}};
        w_v5   = {16{16'h0505}};
        rst = 1'b1;
        a_req = 1'b0; a_addr = 10'd0; a_ld = 1'b0; a_ldaddr = 10'd0; a_lddata = 256'd0;
        bc_req = 1'b0; bc_addr = 10'd0; bc_ld = 1'b0; bc_ldaddr = 10'd0; bc_lddata = 256'd0;
        step();
        mon_en = 1'b1;
        step();
        rst = 1'b0;

        // Preload both arrays.
        for (int i = 0; i < 4; i++) begin
            ld_a(10'(i), w_idx(i));
            step();
        end
        bc_ld = 1'b1; bc_ldaddr = 10'd9; bc_lddata = w_v9;
        ld_a(10'd5, w_a5); step();
        bc_ldaddr = 10'd5; bc_lddata = w_v5;
        ld_a(10'd7, w_x); step();
        bc_ld = 1'b0;
        ld_a(10'd88, w_p88); step();
        ld_a(10'd511, w_z); step();
        ld_a(10'd600, w_j600); step();
        a_ld = 1'b0;

        // Reset keeps array contents; then hold a request for 8 cycles against the duty cycle.
        rst = 1'b1; step(); rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rd_bc(10'd9, w_v9);
            step();
        end
        idle(1);
`ifdef MATRIX_MEM_STAT_EN
        chk("b_req_cnt", 256'(b_rc), 256'(32'd6));
        chk("b_stall_cnt", 256'(b_sc), 256'(32'd2));
`endif
        idle(3);
        rd_bc(10'd5, w_v5); step();
        idle(3);

        // Single read, then four pipelined reads.
        rd_a(10'd5, w_a5); step();
        idle(4);
        for (int i = 0; i < 4; i++) begin
            rd_a(10'(i), w_idx(i));
            step();
        end
        idle(5);

        // Read-first collision on address 7.
        ld_a(10'd7, w_y);
        rd_a(10'd7, w_x); step();
        a_ld = 1'b0;
        rd_a(10'd7, w_y); step();
        idle(4);

        // Out-of-range read and dropped load; address 88 aliases 600 in the low bits.
        rd_a(10'd600, 256'd0); step();
        rd_a(10'd511, w_z); step();
        rd_a(10'd88, w_p88); step();
        idle(5);

        // Reset while two reads are in flight; neither may be delivered.
        rd_a(10'd0, w_idx(0)); step();
        rd_a(10'd1, w_idx(1)); step();
        a_req = 1'b0;
        rst = 1'b1; step(); rst = 1'b0;
        idle(1);
        rd_a(10'd5, w_a5); step();
        idle(6);

        for (int k = 0; k < 3; k++) chk("queue_drained", 256'(q[k].size()), 256'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
